// File: rtl/tx_scheduler.sv
// Two-requester transmit arbiter: latches request pulses with headers, grants the packet transmitter
// and returns per-requester sent pulses. Define TXSCHED_WATCHDOG_EN to enable the SEND-state abort watchdog.
module tx_scheduler #(
    parameter int          ACK_PRIORITY = 0,
    parameter logic [19:0] WATCHDOG_MAX = 20'd650000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] seq0,
    input  logic [31:0] ack0,
    input  logic [8:0]  flags0,
    input  logic        req1,
    input  logic [31:0] seq1,
    input  logic [31:0] ack1,
    input  logic [8:0]  flags1,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [31:0] tx_seq,
    output logic [31:0] tx_ack,
    output logic [8:0]  tx_flags,
    output logic        sent0,
    output logic        sent1,
    output logic        tx_error,
    output logic [7:0]  ovr_count,
    output logic        busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_next;
    logic [1:0]  pending, pending_next;
    logic        last_grant, grant;
    logic [31:0] shadow_seq0, shadow_ack0, shadow_seq1, shadow_ack1;
    logic [8:0]  shadow_flags0, shadow_flags1;

    logic        choose, launch, done, abort;
    logic        over0, over1;
    logic [8:0]  ovr_sum;
    logic [7:0]  ovr_next;
    logic        tx_start_next, sent0_next, sent1_next, tx_error_next;

    // One pending requester wins outright; a tie goes by priority mode or round-robin.
    always_comb begin
        choose = 1'b0;
        if (pending == 2'b10)
            choose = 1'b1;
        else if (pending == 2'b01)
            choose = 1'b0;
        else
            choose = (ACK_PRIORITY != 0) ? 1'b1 : ~last_grant;
    end

    assign launch = (state == IDLE) && (pending != 2'b00);
    assign done   = (state == SEND) && !tx_start && tx_done;

`ifdef TXSCHED_WATCHDOG_EN
    logic [19:0] wd_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wd_count <= 20'd0;
        else if (launch)
            wd_count <= 20'd0;
        else if (state == SEND)
            wd_count <= wd_count + 20'd1;
    end

    assign abort = (state == SEND) && !done && (wd_count == WATCHDOG_MAX - 20'd1);
`else
    logic unused_watchdog_max;
    assign unused_watchdog_max = ^WATCHDOG_MAX;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = SEND;
            SEND:    if (done || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_start_next = launch;
        sent0_next    = done && (grant == 1'b0);
        sent1_next    = done && (grant == 1'b1);
        tx_error_next = abort;
    end

    assign busy = (state == SEND);

    // The in-flight packet leaves pending at grant; a fresh request or an abort re-arms it.
    always_comb begin
        pending_next = pending;
        if (launch)
            pending_next[choose] = 1'b0;
        if (abort)
            pending_next[grant] = 1'b1;
        if (req0)
            pending_next[0] = 1'b1;
        if (req1)
            pending_next[1] = 1'b1;
    end

    assign over0    = req0 && pending[0] && !(launch && (choose == 1'b0));
    assign over1    = req1 && pending[1] && !(launch && (choose == 1'b1));
    assign ovr_sum  = {1'b0, ovr_count} + {8'd0, over0} + {8'd0, over1};
    assign ovr_next = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending       <= 2'b00;
            last_grant    <= 1'b1;
            grant         <= 1'b0;
            shadow_seq0   <= 32'd0;
            shadow_ack0   <= 32'd0;
            shadow_flags0 <= 9'd0;
            shadow_seq1   <= 32'd0;
            shadow_ack1   <= 32'd0;
            shadow_flags1 <= 9'd0;
            tx_seq        <= 32'd0;
            tx_ack        <= 32'd0;
            tx_flags      <= 9'd0;
            tx_start      <= 1'b0;
            sent0         <= 1'b0;
            sent1         <= 1'b0;
            tx_error      <= 1'b0;
            ovr_count     <= 8'd0;
        end else begin
            pending   <= pending_next;
            tx_start  <= tx_start_next;
            sent0     <= sent0_next;
            sent1     <= sent1_next;
            tx_error  <= tx_error_next;
            ovr_count <= ovr_next;
            if (req0) begin
                shadow_seq0   <= seq0;
                shadow_ack0   <= ack0;
                shadow_flags0 <= flags0;
            end
            if (req1) begin
                shadow_seq1   <= seq1;
                shadow_ack1   <= ack1;
                shadow_flags1 <= flags1;
            end
            if (launch) begin
                grant      <= choose;
                last_grant <= choose;
                tx_seq     <= choose ? shadow_seq1   : shadow_seq0;
                tx_ack     <= choose ? shadow_ack1   : shadow_ack0;
                tx_flags   <= choose ? shadow_flags1 : shadow_flags0;
            end
        end
    end

endmodule
